// File: rtl/logic_unit_pkg.sv
// Shared types, opcodes and the bitwise evaluation helper for the logic unit arbiter.
package logic_unit_pkg;

   // Widest operand the shared helper handles; narrower instances zero-extend and truncate.
   localparam int LU_MAX_W = 64;

   typedef logic [1:0]          lu_op_t;
   typedef logic [LU_MAX_W-1:0] lu_word_t;

   localparam lu_op_t LU_OP_OR   = 2'b00;
   localparam lu_op_t LU_OP_AND  = 2'b01;
   localparam lu_op_t LU_OP_XOR  = 2'b10;
   localparam lu_op_t LU_OP_ANDN = 2'b11;

   // Occupancy of the single-entry response register.
   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_e;

   // Pure bitwise result; no carries, so the upper bits stay zero for zero-extended inputs.
   function automatic lu_word_t lu_eval(input lu_op_t op, input lu_word_t a, input lu_word_t b);
      lu_word_t r;
      case (op)
         LU_OP_OR:   r = a | b;
         LU_OP_AND:  r = a & b;
         LU_OP_XOR:  r = a ^ b;
         LU_OP_ANDN: r = a & ~b;
         default:    r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The only state is the priority pointer, which names the
// requester that wins when both are asking.
module rr_arbiter2
   import logic_unit_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic ptr_q;
   logic ptr_d;

   // Winner select: a lone request wins outright, a tie goes to the pointer.
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = ptr_q ? 2'b10 : 2'b01;
      end
   end

   // After a real grant the pointer moves to the requester that lost.
   always_comb begin
      ptr_d = ptr_q;
      if (advance && (gnt != 2'b00)) begin
         ptr_d = gnt[0];
      end
   end

   // Pointer register; reset gives requester 0 first priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one bitwise logic unit between two valid/ready requesters and returns the
// result through a single registered response channel tagged with the requester id.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   RSP_EMPTY | response register idle; any winner is accepted
//   RSP_FULL  | response held; a new winner is accepted only while rsp_ready=1
module logic_unit_arbiter
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,

   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data
);

   rsp_state_e       state_q;
   rsp_state_e       state_d;
   logic             rsp_id_q;
   logic             rsp_id_d;
   logic [WIDTH-1:0] rsp_data_q;
   logic [WIDTH-1:0] rsp_data_d;

   logic [1:0]       gnt;
   logic             can_accept;
   logic             grant;
   lu_op_t           win_op;
   logic [WIDTH-1:0] win_a;
   logic [WIDTH-1:0] win_b;
   logic [WIDTH-1:0] win_result;

   rr_arbiter2 u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     ({req1_valid, req0_valid}),
      .advance (grant),
      .gnt     (gnt)
   );

   // Accept when the register is free or being drained this cycle; nothing is
   // accepted while reset is asserted so no requester sees a handshake then.
   always_comb begin
      can_accept = rst_n && ((state_q == RSP_EMPTY) || rsp_ready);
      grant      = can_accept && (gnt != 2'b00);
      req0_ready = can_accept && gnt[0];
      req1_ready = can_accept && gnt[1];
   end

   // Route the winner's operands into the shared logic unit.
   always_comb begin
      win_op = gnt[1] ? req1_op : req0_op;
      win_a  = gnt[1] ? req1_a  : req0_a;
      win_b  = gnt[1] ? req1_b  : req0_b;
      win_result = WIDTH'(lu_eval(win_op, lu_word_t'(win_a), lu_word_t'(win_b)));
   end

   // Response register occupancy and payload; a grant while FULL refills in place.
   always_comb begin
      state_d    = state_q;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      if (grant) begin
         rsp_id_d   = gnt[1];
         rsp_data_d = win_result;
      end
      case (state_q)
         RSP_EMPTY: begin
            if (grant) begin
               state_d = RSP_FULL;
            end
         end
         RSP_FULL: begin
            if (rsp_ready && !grant) begin
               state_d = RSP_EMPTY;
            end
         end
         default: begin
            state_d = RSP_EMPTY;
         end
      endcase
   end

   // State and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RSP_EMPTY;
         rsp_id_q   <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   // Output view of the response register.
   always_comb begin
      rsp_valid = (state_q == RSP_FULL);
      rsp_id    = rsp_id_q;
      rsp_data  = rsp_data_q;
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench with a response scoreboard: stimulus pushes the hand-computed
// {id, data} it expects, a monitor pops on every response handshake.
module tb_logic_unit_arbiter;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             req0_valid;
   logic             req0_ready;
   logic [1:0]       req0_op;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req1_valid;
   logic             req1_ready;
   logic [1:0]       req1_op;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_data;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct packed {
      logic             id;
      logic [WIDTH-1:0] data;
   } rsp_t;

   rsp_t exp_q[$];

   logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic id, input logic [WIDTH-1:0] data);
      rsp_t e;
      e.id   = id;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Monitor: pop on each handshake, and check the payload holds under backpressure.
   logic             hold_pend = 1'b0;
   logic             hold_id;
   logic [WIDTH-1:0] hold_data;
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_id", 32'(rsp_id), 32'(hold_id));
            check("hold_data", 32'(rsp_data), 32'(hold_data));
         end
         hold_pend = rsp_valid && !rsp_ready;
         hold_id   = rsp_id;
         hold_data = rsp_data;
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL rsp_unexpected: got id %0d data %0h expected no response", rsp_id, rsp_data);
            end else begin
               rsp_t e;
               e = exp_q.pop_front();
               check("rsp_id", 32'(rsp_id), 32'(e.id));
               check("rsp_data", 32'(rsp_data), 32'(e.data));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with both requesters asking.
      rst_n      = 1'b0;
      rsp_ready  = 1'b0;
      req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h12; req0_b = 8'h34;
      req1_valid = 1'b1; req1_op = 2'b00; req1_a = 8'h56; req1_b = 8'h78;
      repeat (3) step();
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'h00);
      check("rst_req0_ready", 32'(req0_ready), 32'd0);
      check("rst_req1_ready", 32'(req1_ready), 32'd0);
      rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      step();

      // Single AND from requester 0.
      req0_valid = 1'b1; req0_op = 2'b01; req0_a = 8'hF0; req0_b = 8'h3C;
      push(1'b0, 8'h30);
      #1;
      check("single_req0_ready", 32'(req0_ready), 32'd1);
      check("single_req1_ready", 32'(req1_ready), 32'd0);
      step();
      req0_valid = 1'b0;
      check("single_rsp_valid", 32'(rsp_valid), 32'd1);

      // Lone requester 1 XOR; moves the pointer back to requester 0.
      req1_valid = 1'b1; req1_op = 2'b10; req1_a = 8'h55; req1_b = 8'hFF;
      push(1'b1, 8'hAA);
      #1;
      check("lone_req1_ready", 32'(req1_ready), 32'd1);
      step();

      // Contention: alternating grants, one response per cycle.
      req0_op = 2'b00; req0_a = 8'h0F; req0_b = 8'hF0;
      req1_op = 2'b10; req1_a = 8'hFF; req1_b = 8'h0F;
      for (int i = 0; i < 4; i++) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
         if (i % 2 == 0) push(1'b0, 8'hFF); else push(1'b1, 8'hF0);
         #1;
         check("cont_req0_ready", 32'(req0_ready), 32'(i % 2 == 0));
         check("cont_req1_ready", 32'(req1_ready), 32'(i % 2 == 1));
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Backpressure: fill, stall five cycles with requester 1 waiting, then drain+refill.
      req0_valid = 1'b1; req0_op = 2'b01; req0_a = 8'hFF; req0_b = 8'h5A;
      push(1'b0, 8'h5A);
      #1;
      check("bp_fill_ready", 32'(req0_ready), 32'd1);
      step();
      req0_valid = 1'b0; rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_op = 2'b00; req1_a = 8'h01; req1_b = 8'h80;
      push(1'b1, 8'h81);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_req1_ready", 32'(req1_ready), 32'd0);
         check("bp_rsp_data", 32'(rsp_data), 32'h5A);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_drain_req1_ready", 32'(req1_ready), 32'd1);
      step();
      req1_valid = 1'b0;

      // ANDN from requester 1, then a tie must go to requester 0, then requester 1.
      req1_valid = 1'b1; req1_op = 2'b11; req1_a = 8'hAA; req1_b = 8'h0F;
      push(1'b1, 8'hA0);
      #1;
      check("andn_req1_ready", 32'(req1_ready), 32'd1);
      step();
      req0_valid = 1'b1; req0_op = 2'b10; req0_a = 8'h3C; req0_b = 8'h3C;
      req1_op = 2'b01; req1_a = 8'h0F; req1_b = 8'hFF;
      push(1'b0, 8'h00);
      #1;
      check("wrap_req0_ready", 32'(req0_ready), 32'd1);
      check("wrap_req1_ready", 32'(req1_ready), 32'd0);
      step();
      req0_valid = 1'b0;
      push(1'b1, 8'h0F);
      #1;
      check("wrap2_req1_ready", 32'(req1_ready), 32'd1);
      step();
      req1_valid = 1'b0;
      repeat (2) step();

      // Reset while FULL under backpressure: response vanishes, pointer returns to 0.
      rsp_ready = 1'b0;
      req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h11; req0_b = 8'h22;
      step();
      req0_valid = 1'b0;
      check("mid_full_valid", 32'(rsp_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(rsp_valid), 32'd0);
      step();
      rst_n = 1'b1; rsp_ready = 1'b1;
      step();
      req0_valid = 1'b1; req0_op = 2'b01; req0_a = 8'h0F; req0_b = 8'h0C;
      req1_valid = 1'b1; req1_op = 2'b00; req1_a = 8'h00; req1_b = 8'h00;
      push(1'b0, 8'h0C);
      #1;
      check("post_rst_req0_ready", 32'(req0_ready), 32'd1);
      check("post_rst_req1_ready", 32'(req1_ready), 32'd0);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (3) step();

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
